// File: rtl/sched_event_recorder.sv
// Timestamped recorder for warp-control, warp-spawn and active-mask events.
// Optional PC capture: define SCHED_REC_PC_EN to add result_pc / evt_pc.
module sched_event_recorder #(
    parameter int NUM_WARPS = 4,
    parameter int NW_WIDTH  = 2,
    parameter int PC_BITS   = 30,
    parameter int DEPTH     = 8,
    parameter int TS_BITS   = 16,
    parameter int CNT_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 warp_ctl_valid,
    input  logic                 wspawn_valid,
    input  logic [NW_WIDTH-1:0]  wid,
    input  logic [NUM_WARPS-1:0] active_warps,
    input  logic [NUM_WARPS-1:0] stalled_warps,
`ifdef SCHED_REC_PC_EN
    input  logic [PC_BITS-1:0]   result_pc,
    output logic [PC_BITS-1:0]   evt_pc,
`endif
    output logic                 evt_valid,
    input  logic                 evt_ready,
    output logic [2:0]           evt_type,
    output logic [NW_WIDTH-1:0]  evt_wid,
    output logic [NUM_WARPS-1:0] evt_active,
    output logic [NUM_WARPS-1:0] evt_stalled,
    output logic [TS_BITS-1:0]   evt_ts,
    output logic                 overflow,
    output logic [CNT_BITS-1:0]  drop_cnt
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
`ifdef SCHED_REC_PC_EN
        logic [PC_BITS-1:0]   pc;
`endif
        logic [TS_BITS-1:0]   ts;
        logic [NUM_WARPS-1:0] stalled;
        logic [NUM_WARPS-1:0] active;
        logic [NW_WIDTH-1:0]  wid;
        logic [2:0]           typ;
    } rec_t;

    rec_t mem_q [DEPTH];
    rec_t wr_rec;
    rec_t head;

    logic [AW:0]            wptr_q, wptr_d;
    logic [AW:0]            rptr_q, rptr_d;
    logic [TS_BITS-1:0]     ts_q, ts_d;
    logic [NUM_WARPS-1:0]   prev_q, prev_d;
    logic                   ovf_q, ovf_d;
    logic [CNT_BITS-1:0]    drop_q, drop_d;

    logic act_chg, evt, full, empty, push, pop, drop;

    assign act_chg = (active_warps != prev_q);
    assign evt     = warp_ctl_valid | wspawn_valid | act_chg;
    assign empty   = (wptr_q == rptr_q);
    assign full    = (wptr_q[AW] != rptr_q[AW])
                  && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop     = !empty && evt_ready;
    // A pop in the same cycle frees the slot the new record needs.
    assign push    = evt && (!full || pop);
    assign drop    = evt && full && !pop;

    always_comb begin
        wr_rec         = '0;
        wr_rec.typ     = {act_chg, wspawn_valid, warp_ctl_valid};
        wr_rec.wid     = wid;
        wr_rec.active  = active_warps;
        wr_rec.stalled = stalled_warps;
        wr_rec.ts      = ts_q;
`ifdef SCHED_REC_PC_EN
        wr_rec.pc      = result_pc;
`endif
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ovf_d  = ovf_q;
        drop_d = drop_q;
        ts_d   = ts_q + TS_BITS'(1);
        prev_d = active_warps;
        if (push) wptr_d = wptr_q + (AW+1)'(1);
        if (pop)  rptr_d = rptr_q + (AW+1)'(1);
        if (drop) begin
            ovf_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ts_q   <= '0;
            prev_q <= '0;
            ovf_q  <= 1'b0;
            drop_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ts_q   <= ts_d;
            prev_q <= prev_d;
            ovf_q  <= ovf_d;
            drop_q <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q[AW-1:0]] <= wr_rec;
    end

    // Data outputs read as zero whenever nothing valid is at the head.
    assign head        = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign evt_valid   = !empty;
    assign evt_type    = head.typ;
    assign evt_wid     = head.wid;
    assign evt_active  = head.active;
    assign evt_stalled = head.stalled;
    assign evt_ts      = head.ts;
`ifdef SCHED_REC_PC_EN
    assign evt_pc      = head.pc;
`endif
    assign overflow    = ovf_q;
    assign drop_cnt    = drop_q;

endmodule

// File: doc/sched_event_recorder.md
# sched_event_recorder

Event recorder downstream of the warp scheduler's control/spawn observation points. Each cycle it samples warp-control, warp-spawn and active-mask activity, packs any event into a timestamped record, and buffers the record in a FIFO. A consumer (trace dumper or scoreboard) drains the FIFO over a valid/ready handshake. Overflow is flagged and counted, never silently lost.

## Interface
- NUM_WARPS, 4, warps per core; width of mask ports
- NW_WIDTH, 2, wid width; equals clog2(NUM_WARPS), minimum 1
- PC_BITS, 30, PC width
- DEPTH, 8, FIFO entries; power of two, ≥2
- TS_BITS, 16, timestamp width
- CNT_BITS, 8, drop-counter width

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- warp_ctl_valid  in  1  warp-control instruction executed this cycle
- wspawn_valid  in  1  warp-spawn request this cycle
- wid  in  NW_WIDTH  warp id associated with warp_ctl_valid
- active_warps  in  NUM_WARPS  current active-warp mask
- stalled_warps  in  NUM_WARPS  current stalled-warp mask
- result_pc  in  PC_BITS  PC result of the control op (only with SCHED_REC_PC_EN)
- evt_valid  out  1  head record valid
- evt_ready  in  1  consumer accepts head record
- evt_type  out  3  {act_chg, wspawn, wctl} bit mask
- evt_wid  out  NW_WIDTH  captured wid
- evt_active  out  NUM_WARPS  captured active_warps
- evt_stalled  out  NUM_WARPS  captured stalled_warps
- evt_ts  out  TS_BITS  capture timestamp
- evt_pc  out  PC_BITS  captured result_pc (only with SCHED_REC_PC_EN)
- overflow  out  1  sticky: at least one record dropped
- drop_cnt  out  CNT_BITS  dropped-record count, saturating

## Operation
- Timestamp counter ts: increments every cycle, wraps from 2^TS_BITS-1 to 0.
- prev_active register: holds active_warps from previous cycle; act_chg = (active_warps != prev_active).
- Event this cycle when any of wctl, wspawn, act_chg is set; exactly one record per cycle, type is the OR mask of all three sources.
- Record fields sampled from the same cycle's inputs plus current ts.
- FIFO: DEPTH entries, read/write pointers with wrap bit; full = pointers equal except wrap bit; empty = equal.
- Push when event and (not full, or pop in same cycle).
- Pop when evt_valid && evt_ready.
- Event while full with no simultaneous pop: record dropped; overflow set; drop_cnt += 1, saturating at all-ones.
- overflow and drop_cnt clear only on reset.
- evt_* outputs show the head entry. They hold stable while evt_valid && !evt_ready.

## Timing
- Reset (reset=0, asynchronous):
  - FIFO empty; evt_valid=0; ts=0; prev_active=0; overflow=0; drop_cnt=0.
  - evt_* data outputs=0.
- Reset mid-operation discards all buffered records immediately.
- Latency: an event in cycle N with an empty FIFO gives evt_valid=1 in cycle N+1, with evt_ts = ts value of cycle N.
- First cycle after reset release: ts=0. A nonzero active_warps produces an act_chg record, because prev_active=0.
- Push and pop in the same cycle with FIFO full: both occur; occupancy unchanged; no drop.
- Push and pop in the same cycle with one entry: head advances to the new record the next cycle; evt_valid stays 1.
- Timestamp wrap does not affect FIFO ordering. Records carry raw wrapped ts.

## Configuration
- SCHED_REC_PC_EN defined:
  - result_pc input and evt_pc output exist.
  - result_pc is captured per record; FIFO entry widens by PC_BITS.
- SCHED_REC_PC_EN undefined:
  - both ports absent; no PC storage.
  - All other behaviour identical.

## Test plan
- Reset, then active_warps=4'b0001 held, evt_ready=1:
  - exactly one record: type=3'b100, active=0001, ts=0;
  - no further records while the mask is stable.
- wctl_valid=1 with wid=2 and wspawn_valid=1 in the same cycle, mask unchanged -> one record with type=3'b011, wid=2.
- evt_ready=0 with DEPTH=8 and 10 consecutive wctl events:
  - evt_valid=1 throughout; 8 records stored;
  - overflow=1, drop_cnt=2;
  - draining returns ts values in increasing order, first 8 events only.
- FIFO full, and event plus evt_ready=1 in the same cycle -> no drop (drop_cnt unchanged); occupancy stays 8.
- TS_BITS=4, event at ts=15 then next cycle at ts=0 -> records read out in order with evt_ts 15 then 0.
- Assert reset with 5 records buffered -> evt_valid=0 immediately; overflow=0, drop_cnt=0; ts restarts at 0 after release.
